// File: rtl/smart_ram_ctrl.sv
// smart_ram_ctrl
//   Responder end of the effect-side smart_ram request interface. Each request
//   is one read, one write, or a read-then-write. The request offset is mapped
//   into a circular delay buffer in external async SRAM. The mapping is relative
//   to a ring pointer that advances once per audio sample.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   advance             sample tick, bumps the ring pointer
//   req_rd / req_wr     one-cycle request strobes (both = read-before-write)
//   req_offset          delay offset of the request
//   req_data            write data
//   rd_data             read result, valid with read_finish, held until next read
//   read_finish         one-cycle read completion pulse
//   write_finish        one-cycle write completion pulse
//   ready               idle and accepting requests
//   overrun             sticky: a request arrived while not accepting
//   sram_*              async SRAM pins (strobes active-low, dq split in/out/oe)
//
// Build option
//   SMART_RAM_CLEAR_EN  when defined, the whole ring is zero-filled after reset
//                       before the first request is accepted.
module smart_ram_ctrl #(
    parameter int                         DATA_WIDTH     = 16,
    parameter int                         ADDR_WIDTH     = 12,
    parameter int                         MEM_ADDR_WIDTH = 18,
    parameter logic [MEM_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int                         WAIT_CYCLES    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    input  logic                      req_rd,
    input  logic                      req_wr,
    input  logic [ADDR_WIDTH-1:0]     req_offset,
    input  logic [DATA_WIDTH-1:0]     req_data,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      read_finish,
    output logic                      write_finish,
    output logic                      ready,
    output logic                      overrun,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_dq_out,
    input  logic [DATA_WIDTH-1:0]     sram_dq_in,
    output logic                      sram_dq_oe,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n
);

    typedef enum logic [2:0] {IDLE, READ, RFIN, WRITE, WREC, WFIN} state_t;

    state_t                      state, state_d;
    logic [3:0]                  cnt, cnt_d;
    logic                        wr_pend, wr_pend_d;
    logic [ADDR_WIDTH-1:0]       ptr;
    logic [ADDR_WIDTH-1:0]       ring_idx;
    logic [MEM_ADDR_WIDTH-1:0]   req_addr;
    logic [MEM_ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]       dq_d;
    logic                        capture;
    logic                        clearing;
    logic                        clearing_d;

`ifdef SMART_RAM_CLEAR_EN
    logic                        clr_act, clr_act_d;
    logic [ADDR_WIDTH-1:0]       clr_idx, clr_idx_d;
    assign clearing   = clr_act;
    assign clearing_d = clr_act_d;
`else
    assign clearing   = 1'b0;
    assign clearing_d = 1'b0;
`endif

    // Ring arithmetic wraps naturally at ADDR_WIDTH bits; BASE_ADDR is aligned
    // to the ring size, so the add never carries into the ring index.
    assign ring_idx = ptr - req_offset;
    assign req_addr = BASE_ADDR + MEM_ADDR_WIDTH'(ring_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= '0;
        else if (advance) ptr <= ptr + 1'b1;
    end

    // Next state plus the values loaded into the registered SRAM/handshake
    // outputs. Every output is decoded from the next state, so the pins
    // change on the same edge as the state register.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wr_pend_d = wr_pend;
        addr_d    = sram_addr;
        dq_d      = sram_dq_out;
        capture   = 1'b0;
`ifdef SMART_RAM_CLEAR_EN
        clr_act_d = clr_act;
        clr_idx_d = clr_idx;
`endif
        unique case (state)
            IDLE: begin
`ifdef SMART_RAM_CLEAR_EN
                if (clr_act) begin
                    state_d = WRITE;
                    cnt_d   = 4'(WAIT_CYCLES);
                    addr_d  = BASE_ADDR + MEM_ADDR_WIDTH'(clr_idx);
                    dq_d    = '0;
                end else
`endif
                if (req_rd) begin
                    state_d   = READ;
                    cnt_d     = 4'(WAIT_CYCLES);
                    addr_d    = req_addr;
                    wr_pend_d = req_wr;
                    if (req_wr) dq_d = req_data;
                end else if (req_wr) begin
                    state_d = WRITE;
                    cnt_d   = 4'(WAIT_CYCLES);
                    addr_d  = req_addr;
                    dq_d    = req_data;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = RFIN;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RFIN: begin
                if (wr_pend) begin
                    state_d   = WRITE;
                    cnt_d     = 4'(WAIT_CYCLES);
                    wr_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt == '0) state_d = WREC;
                else           cnt_d   = cnt - 4'd1;
            end
            WREC: state_d = WFIN;
            WFIN: begin
                state_d = IDLE;
`ifdef SMART_RAM_CLEAR_EN
                // Chain straight into the next clear location so each word
                // costs exactly one WRITE/WREC/WFIN pass.
                if (clr_act) begin
                    if (clr_idx == '1) begin
                        clr_act_d = 1'b0;
                    end else begin
                        clr_idx_d = clr_idx + 1'b1;
                        state_d   = WRITE;
                        cnt_d     = 4'(WAIT_CYCLES);
                        addr_d    = BASE_ADDR + MEM_ADDR_WIDTH'(clr_idx_d);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_pend      <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            rd_data      <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            read_finish  <= 1'b0;
            write_finish <= 1'b0;
            overrun      <= 1'b0;
`ifdef SMART_RAM_CLEAR_EN
            ready        <= 1'b0;
            clr_act      <= 1'b1;
            clr_idx      <= '0;
`else
            ready        <= 1'b1;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            wr_pend      <= wr_pend_d;
            sram_addr    <= addr_d;
            sram_dq_out  <= dq_d;
            if (capture) rd_data <= sram_dq_in;
            sram_ce_n    <= !(state_d == READ || state_d == WRITE || state_d == WREC);
            sram_oe_n    <= !(state_d == READ);
            sram_we_n    <= !(state_d == WRITE);
            sram_dq_oe   <= (state_d == WRITE || state_d == WREC);
            read_finish  <= (state_d == RFIN);
            // Clear passes run through WFIN silently.
            write_finish <= (state_d == WFIN) && !clearing;
            ready        <= (state_d == IDLE) && !clearing_d;
            if ((req_rd || req_wr) && (state != IDLE || clearing))
                overrun <= 1'b1;
`ifdef SMART_RAM_CLEAR_EN
            clr_act      <= clr_act_d;
            clr_idx      <= clr_idx_d;
`endif
        end
    end

endmodule

// File: doc/smart_ram_ctrl.md
Name: smart_ram_ctrl

Overview:
Responder end of the effect-side smart_ram request interface. Serves one read or write per request from the effect currently holding its turn. Each request carries a delay offset, which the block maps into a circular delay buffer in external asynchronous SRAM relative to a write pointer that advances once per audio sample. The block drives the SRAM pins with fixed wait states and returns one-cycle finish pulses to the requester.

Parameters:
DATA_WIDTH, 16, sample/word width.
ADDR_WIDTH, 12, offset and ring-pointer width; ring depth = 2^ADDR_WIDTH words.
MEM_ADDR_WIDTH, 18, external SRAM address width.
BASE_ADDR, 0, ring start in SRAM; must be aligned to 2^ADDR_WIDTH.
WAIT_CYCLES, 1, extra SRAM access cycles, range 0..15.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-low.
advance  in  1  one-cycle sample tick; increments the ring pointer.
req_rd  in  1  one-cycle read request.
req_wr  in  1  one-cycle write request.
req_offset  in  ADDR_WIDTH  delay offset of the request.
req_data  in  DATA_WIDTH  write data.
rd_data  out  DATA_WIDTH  read result.
read_finish  out  1  one-cycle pulse; rd_data is valid.
write_finish  out  1  one-cycle pulse; write is committed.
ready  out  1  high when the block is IDLE and able to accept a request.
overrun  out  1  sticky flag: a request arrived while busy.
sram_addr  out  MEM_ADDR_WIDTH  SRAM address.
sram_dq_out  out  DATA_WIDTH  SRAM write data.
sram_dq_in  in  DATA_WIDTH  SRAM read data.
sram_dq_oe  out  1  drives the data bus (tristate enable).
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset values: ptr=0, sram_addr=0, sram_dq_out=0, rd_data=0, dq_oe=0, ce_n=oe_n=we_n=1, both finish pulses=0, overrun=0, state=IDLE, ready=1 (see Optional Feature). Reset takes effect immediately, including mid-access, and emits no finish pulse.
- ptr increments on every clock with advance=1, in any state, wrapping mod 2^ADDR_WIDTH.
- Address computation: sram_addr = BASE_ADDR + ((ptr - req_offset) mod 2^ADDR_WIDTH). Uses the ptr value before any same-cycle advance. Latched at acceptance, so a later advance does not affect an access in flight.
- Requests are accepted only in IDLE. Outputs are registered.
- State machine:
  - IDLE: req_rd -> READ. req_wr only -> WRITE, with req_data latched. req_rd and req_wr together -> READ then WRITE at the same address (read-before-write, returns the old value); req_data is latched at acceptance.
  - READ: ce_n=oe_n=0 for WAIT_CYCLES+1 cycles. sram_dq_in is captured into rd_data on the last cycle, then -> RFIN.
  - RFIN: read_finish=1 for one cycle. -> WRITE if a write is pending, else -> IDLE.
  - WRITE: ce_n=0, dq_oe=1, we_n=0 for WAIT_CYCLES+1 cycles, then -> WREC.
  - WREC: we_n=1 with addr/data/dq_oe held for one cycle, then -> WFIN.
  - WFIN: write_finish=1 for one cycle, dq_oe=0, then -> IDLE.
- Latency, counting the request cycle as 0: read_finish in cycle WAIT_CYCLES+2; write_finish in cycle WAIT_CYCLES+3. For a combined request, write_finish comes WAIT_CYCLES+3 cycles after read_finish.
- rd_data holds its value until the next read capture.
- oe_n and we_n are never low in the same cycle. dq_oe is never high while oe_n is low.
- A req_rd or req_wr in a non-IDLE state is ignored and sets overrun, which stays set until reset.

Optional Feature:
SMART_RAM_CLEAR_EN
- Defined: after reset release, the block writes zero to all 2^ADDR_WIDTH ring locations using the normal WRITE/WREC timing, without write_finish pulses. ready stays 0 until the clear completes. Requests during the clear are ignored and set overrun. advance still moves ptr.
- Not defined: ready=1 on the first cycle after reset; ring contents are undefined.

Test Plan:
- WAIT_CYCLES=1, ptr=0: req_wr offset 0, data 0x1234 -> we_n low 2 cycles at addr BASE_ADDR, write_finish in cycle 4. Then req_rd offset 0 -> rd_data=0x1234, read_finish in cycle 3.
- ptr=0: req_rd offset 1 -> sram_addr=BASE_ADDR+4095 (wrap). After 3 advances, offset 1 -> BASE_ADDR+2.
- Location holds 0x00AA; req_rd+req_wr together, offset 5, data 0x5555 -> rd_data=0x00AA; read_finish precedes write_finish by 4 cycles; memory then holds 0x5555.
- req_rd accepted; req_wr two cycles later -> write ignored, overrun=1 and stays 1; only read_finish pulses.
- rst low during WRITE -> we_n=1, dq_oe=0 asynchronously; no write_finish; ready=1 after release.
- SMART_RAM_CLEAR_EN, ADDR_WIDTH=4, WAIT_CYCLES=0: ready low for 16x3 cycles after reset, then a read at any offset returns 0x0000.
